// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes and immediate
// range helpers used by the encoder and by the decoder round-trip bench.
package rv32i_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } format_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // A value fits an N-bit signed field when every bit above N-1 matches the sign bit.
    function automatic logic fits_simm12(input logic [31:0] v);
        return v == {{20{v[11]}}, v[11:0]};
    endfunction

    function automatic logic fits_simm13(input logic [31:0] v);
        return v == {{19{v[12]}}, v[12:0]};
    endfunction

    function automatic logic fits_simm21(input logic [31:0] v);
        return v == {{11{v[20]}}, v[20:0]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is readable in the cycle after
// it is written, so an empty-FIFO push reaches the consumer with one cycle latency.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_instruction_encoder.sv
// Packs decoded RV32I fields into instruction words, drops illegal requests
// with a sticky error, and queues {word, address} pairs for the consumer.
module rv32i_instruction_encoder
    import rv32i_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        restart,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_format,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_address,
    output logic        error,
    output logic [15:0] error_index,
    output logic [15:0] emitted_count
);
    logic [31:0] addr_reg;
    logic [15:0] req_index_reg;
    logic        error_reg;
    logic [15:0] error_index_reg;
    logic [15:0] emitted_reg;

    logic [31:0] enc_word;
    logic        imm_ok;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [63:0] head_data;

    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b0;
        case (req_format)
            FMT_R: begin
                enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
                imm_ok   = 1'b1;
            end
            FMT_I: begin
                enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
                imm_ok   = fits_simm12(req_imm);
            end
            FMT_S: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
                imm_ok   = fits_simm12(req_imm);
            end
            FMT_B: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], req_opcode};
                imm_ok   = fits_simm13(req_imm) && !req_imm[0];
            end
            FMT_U: begin
                enc_word = {req_imm[31:12], req_rd, req_opcode};
                imm_ok   = (req_imm[11:0] == 12'h000);
            end
            FMT_J: begin
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, req_opcode};
                imm_ok   = fits_simm21(req_imm) && !req_imm[0];
            end
            default: begin
                enc_word = '0;
                imm_ok   = 1'b0;
            end
        endcase
    end

    assign legal     = imm_ok && (req_opcode[1:0] == 2'b11);
    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready && !restart;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({enc_word, addr_reg}),
        .pop       (pop),
        .pop_data  (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Stale RAM contents are masked so an empty FIFO presents all-zero outputs.
    assign out_valid       = !fifo_empty;
    assign out_instruction = out_valid ? head_data[63:32] : '0;
    assign out_address     = out_valid ? head_data[31:0]  : '0;
    assign error           = error_reg;
    assign error_index     = error_index_reg;
    assign emitted_count   = emitted_reg;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            addr_reg        <= START_ADDR;
            req_index_reg   <= '0;
            error_reg       <= 1'b0;
            error_index_reg <= '0;
            emitted_reg     <= '0;
        end else begin
            if (accept) begin
                req_index_reg <= req_index_reg + 16'd1;
                if (legal) begin
                    addr_reg <= addr_reg + 32'd4;
                end else begin
                    error_reg <= 1'b1;
                    if (!error_reg) begin
                        error_index_reg <= req_index_reg;
                    end
                end
            end
            if (pop) begin
                emitted_reg <= emitted_reg + 16'd1;
            end
        end
    end

endmodule

// File: doc/rv32i_instruction_encoder.md
Name: rv32i_instruction_encoder

Overview:
- Inverse of the core's instruction decoder: accepts decoded RV32I fields (format, opcode, funct3, funct7, register addresses, immediate) and packs them into 32-bit instruction words.
- Range-checks each immediate, tags each valid word with a sequential PC-style address, and buffers results in a small output FIFO with valid/ready handshakes on both sides.
- Feeds the boot/debug program loader and the decoder's round-trip verification bench.

Parameters:
- START_ADDR, 32'h00000000, address tagged onto the first word after reset or restart.
- DEPTH, 2, output FIFO entries (power of two, >=2).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- restart  input  1  one-cycle pulse: reload address counter to START_ADDR, clear error flag and count
- req_valid  input  1  request fields valid
- req_ready  output  1  encoder can accept a request this cycle
- req_format  input  3  0=R,1=I,2=S,3=B,4=U,5=J; 6,7 illegal
- req_opcode  input  7  opcode field
- req_funct3  input  3  funct3 field
- req_funct7  input  7  funct7 field (R only)
- req_rd  input  5  destination register
- req_rs1  input  5  source register 1
- req_rs2  input  5  source register 2
- req_imm  input  32  unencoded immediate value (byte offset for B/J, full value with low 12 bits zero for U)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_instruction  output  32  encoded word
- out_address  output  32  tagged address
- error  output  1  sticky: an illegal request was dropped
- error_index  output  16  request index (valid or not) of the first illegal request
- emitted_count  output  16  words emitted since reset/restart, wraps

Behaviour:
- Reset:
  - All outputs 0, FIFO empty, address counter = START_ADDR.
  - req_ready = 1 after the reset cycle.
- Accept:
  - A request is accepted when req_valid && req_ready.
  - req_ready = !full, computed from the registered FIFO count. There is no combinational path from out_ready.
- Latency: a legal request accepted in cycle N appears at the FIFO head with out_valid=1 in cycle N+1 if the FIFO was empty.
- Encoding (RISC-V base ISA placements):
  - R, I, S, B, U, J bit placements follow the RISC-V base ISA.
  - Fields unused by a format are ignored; funct7 is used only for R.
- Legality (any failure means the request is accepted but dropped):
  - opcode[1:0] == 2'b11.
  - format <= 5.
  - I/S: imm fits a 12-bit signed value.
  - B: fits 13-bit signed and imm[0]=0.
  - U: imm[11:0]=0.
  - J: fits 21-bit signed and imm[0]=0.
- Dropped request:
  - No FIFO write and no address increment.
  - error set to 1. error_index captures the running request index on the first failure only.
  - The request index counts all accepted requests.
- Address tagging: each legal word takes the current counter value, then the counter adds 4 (mod 2^32, wraps silently).
- FIFO:
  - Pop on out_valid && out_ready. Simultaneous push and pop when full is not possible because req_ready=0.
  - Simultaneous push and pop otherwise leaves the count unchanged.
  - emitted_count increments on each pop.
- restart:
  - Takes priority over an accept in the same cycle; that request is discarded and not counted.
  - Does not flush FIFO contents.
- reset mid-stream: FIFO flushed, all state returns to reset values next cycle.

Decomposition:
- Shared package rv32i_pkg:
  - format enum.
  - Opcode constants.
  - Immediate-range helper functions, reusable by the decoder bench.
- Sub-module sync_fifo, width 64 (instruction + address), parameter DEPTH, synchronous reset.
- Encoding and legality checks are combinational in the top module.

Test Plan:
- Reset then I-format ADDI (opcode 0x13, rd=1, rs1=0, funct3=0, imm=5):
  - out_instruction=0x00500093, out_address=0x0, out_valid one cycle after accept.
- Stream with out_ready=1: R ADD (0x33, rd=3, rs1=1, rs2=2) -> 0x002081B3; S SW (0x23, f3=2, rs1=1, rs2=2, imm=8) -> 0x0020A423; B BEQ (0x63, imm=-4) -> 0xFE000EE3.
  - Expected addresses 0, 4, 8.
- U LUI (0x37, rd=5, imm=0x12345000) -> 0x123452B7; J JAL (0x6F, rd=1, imm=2048) -> 0x001000EF.
- Illegal handling:
  - Request 0 is legal; request 1 is B with imm=3.
  - Request 1 is dropped; error=1, error_index=1, next legal word tagged 0x4.
  - A second illegal request leaves error_index at 1.
- Backpressure with out_ready=0 and 3 requests offered:
  - 2 accepted, req_ready=0 after the second.
  - Raising out_ready drains words in order and then accepts the third; emitted_count=3.
- Boundaries:
  - restart asserted together with req_valid: request discarded, next word tagged START_ADDR, error cleared.
  - Address wrap: counter at 0xFFFFFFFC emits that tag, then the next tag is 0x0.
